okfifo64x8_ctrl: RTL and testbench



---
 rtl/okfifo64x8_ctrl.sv | 96 +++++++++
 tb/tb_okfifo64x8_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/okfifo64x8_ctrl.sv
// 64x8 single-clock FIFO around a dual-port distributed RAM. Write: 1 cycle to empty deassert.
// Read: registered dout/valid one cycle after an accepted rd_en. No backpressure: refused requests pulse overflow/underflow.

module okDRAM64X8D (
    input  logic       wclk,
    input  logic       we,
    input  logic [5:0] addra,
    input  logic [5:0] addrb,
    input  logic [7:0] din,
    output logic [7:0] douta,
    output logic [7:0] doutb
);
    logic [7:0] mem [64];

    always_ff @(posedge wclk) begin
        if (we) begin
            mem[addra] <= din;
        end
    end

    // Asynchronous read on both ports, as in distributed RAM.
    assign douta = mem[addra];
    assign doutb = mem[addrb];
endmodule

module okfifo64x8_ctrl #(
    parameter int ALMOST_FULL_THRESH  = 56,
    parameter int ALMOST_EMPTY_THRESH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] din,
    output logic       full,
    output logic       almost_full,
    output logic       overflow,
    input  logic       rd_en,
    output logic [7:0] dout,
    output logic       valid,
    output logic       empty,
    output logic       almost_empty,
    output logic       underflow,
    output logic [6:0] count
);
    logic [5:0] wptr;
    logic [5:0] rptr;
    logic       wr_acc;
    logic       rd_acc;
    logic [7:0] ram_doutb;
    logic [7:0] ram_douta_unused;

    // Acceptance is judged on the registered flags only, so a read and a
    // write in the same cycle never see each other's effect.
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    okDRAM64X8D u_ram (
        .wclk  (clk),
        .we    (wr_acc),
        .addra (wptr),
        .addrb (rptr),
        .din   (din),
        .douta (ram_douta_unused),
        .doutb (ram_doutb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr      <= 6'd0;
            rptr      <= 6'd0;
            count     <= 7'd0;
            dout      <= 8'h00;
            valid     <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + 6'd1;
            end
            if (rd_acc) begin
                rptr <= rptr + 6'd1;
                dout <= ram_doutb;
            end
            valid     <= rd_acc;
            overflow  <= wr_en & full;
            underflow <= rd_en & empty;
            count     <= count + 7'(wr_acc) - 7'(rd_acc);
        end
    end

    // Flags decode the occupancy count, never pointer equality.
    assign full         = (count == 7'd64);
    assign empty        = (count == 7'd0);
    assign almost_full  = (count >= 7'(ALMOST_FULL_THRESH));
    assign almost_empty = (count <= 7'(ALMOST_EMPTY_THRESH));
endmodule

// File: tb/tb_okfifo64x8_ctrl.sv
// Directed bench for okfifo64x8_ctrl with a byte-queue scoreboard and occupancy model.
module tb_okfifo64x8_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] din;
    logic       full;
    logic       almost_full;
    logic       overflow;
    logic       rd_en;
    logic [7:0] dout;
    logic       valid;
    logic       empty;
    logic       almost_empty;
    logic       underflow;
    logic [6:0] count;

    okfifo64x8_ctrl #(.ALMOST_FULL_THRESH(56), .ALMOST_EMPTY_THRESH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .din          (din),
        .full         (full),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .rd_en        (rd_en),
        .dout         (dout),
        .valid        (valid),
        .empty        (empty),
        .almost_empty (almost_empty),
        .underflow    (underflow),
        .count        (count)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] sb_q[$];
    int         mc = 0;
    logic [7:0] exp_dout = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, update the model, then check all outputs #1 after the edge.
    task automatic step(input logic rst, input logic w, input logic [7:0] d, input logic r);
        logic wa, ra, e_ovf, e_udf, e_vld;
        reset = rst;
        wr_en = w;
        din   = d;
        rd_en = r;
        if (rst) begin
            sb_q.delete();
            mc = 0;
            exp_dout = 8'h00;
            e_vld = 1'b0;
            e_ovf = 1'b0;
            e_udf = 1'b0;
        end else begin
            wa    = w && (mc < 64);
            ra    = r && (mc > 0);
            e_ovf = w && (mc == 64);
            e_udf = r && (mc == 0);
            e_vld = ra;
            if (ra) exp_dout = sb_q.pop_front();
            if (wa) sb_q.push_back(d);
            mc = mc + int'(wa) - int'(ra);
        end
        @(posedge clk);
        #1;
        chk("valid", valid, e_vld);
        chk("dout", dout, exp_dout);
        chk("count", count, mc);
        chk("full", full, mc == 64);
        chk("almost_full", almost_full, mc >= 56);
        chk("empty", empty, mc == 0);
        chk("almost_empty", almost_empty, mc <= 8);
        chk("overflow", overflow, e_ovf);
        chk("underflow", underflow, e_udf);
    endtask

    initial begin
        int wrote;
        int iter;
        logic w;
        logic r;

        // Reset, idle, then a lone read from empty.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Fill to full, one refused write, then drain in order.
        for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
        step(1'b0, 1'b1, 8'hAA, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 64; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // 200 bytes with random gaps, occupancy kept at or below 10, across pointer wraps.
        wrote = 0;
        iter  = 0;
        while ((wrote < 200 || mc > 0) && iter < 4000) begin
            w = (wrote < 200) && (mc < 10) && ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 2) == 0);
            step(1'b0, w, 8'(wrote * 7 + 3), r);
            if (w) wrote++;
            iter++;
        end
        chk("wrap_budget", 32'(iter < 4000), 1);
        chk("wrap_drained", empty, 1);

        // Simultaneous read and write on empty: write wins, read refused.
        step(1'b0, 1'b1, 8'h5A, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Simultaneous read and write on full: read wins, 0xC3 is dropped.
        for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
        step(1'b0, 1'b1, 8'hC3, 1'b1);
        for (int i = 0; i < 63; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Reset mid-operation with both requests active.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        step(1'b1, 1'b1, 8'hEE, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h11, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
